// File: rtl/mac_ram_scheduler.sv
// Shared RAM port scheduler for the Mac Plus core: 8-phase bus counter, slot arbitration, RAM strobes and CPU ack.
// Optional build macro MEM_ARB_CPU_STEAL_EN lets the CPU take otherwise idle video slots.
module mac_ram_scheduler #(
  parameter int ADDR_W         = 21,
  parameter int REFRESH_PERIOD = 64
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              clk8_en_p,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [1:0]        cpu_ds,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  input  logic              snd_req,
  input  logic [ADDR_W-1:0] snd_addr,
  output logic [2:0]        bus_phase,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [1:0]        ram_ds,
  output logic              ram_oe,
  output logic              ram_we,
  output logic              ram_refresh,
  output logic              cpu_ack,
  output logic              vid_valid,
  output logic              snd_valid,
  output logic [1:0]        slot_owner
);

  // Handshake: cpu_req is a level held for the whole access; cpu_ack answers it in phases 4..7 of the
  // granted slot and never re-asserts once cpu_req has dropped within that slot.
  typedef enum logic [1:0] {OWN_IDLE = 2'd0, OWN_CPU = 2'd1, OWN_VID = 2'd2, OWN_REF = 2'd3} owner_t;

  localparam int CNT_W = $clog2(REFRESH_PERIOD);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_PERIOD - 1);

  logic [2:0]        r_phase, w_phase_nxt;
  logic              r_slot_vid, w_slot_vid_nxt;
  owner_t            r_owner, w_owner_nxt;
  logic              r_snd, w_snd_nxt;
  logic              r_we, w_we_nxt;
  logic              r_ack_ok, w_ack_ok_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic              r_pending, w_pending_nxt;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt;
  logic [1:0]        r_ds, w_ds_nxt;
  logic              r_oe, r_wen, r_refresh, r_ack, r_vid_valid, r_snd_valid;
  logic              w_oe, w_wen, w_refresh, w_ack, w_vid_valid, w_snd_valid;
  logic              w_wrap, w_cpu_nxt, w_rd_span, w_wr_span;

  always_comb begin
    w_wrap         = clk8_en_p && (r_phase == 3'd7);
    w_phase_nxt    = clk8_en_p ? r_phase + 3'd1 : r_phase;
    w_slot_vid_nxt = w_wrap ? ~r_slot_vid : r_slot_vid;
    w_owner_nxt    = r_owner;
    w_snd_nxt      = r_snd;
    w_we_nxt       = r_we;
    w_ack_ok_nxt   = r_ack_ok & cpu_req;
    w_cnt_nxt      = r_cnt;
    w_pending_nxt  = r_pending;
    w_addr_nxt     = r_addr;
    w_ds_nxt       = r_ds;

    if (w_wrap) begin
      w_owner_nxt  = OWN_IDLE;
      w_snd_nxt    = 1'b0;
      w_we_nxt     = 1'b0;
      w_ack_ok_nxt = 1'b0;
      w_addr_nxt   = '0;
      w_ds_nxt     = 2'b00;
      if (w_slot_vid_nxt) begin
        if (vid_req) begin
          w_owner_nxt = OWN_VID;
          w_addr_nxt  = vid_addr;
          w_ds_nxt    = 2'b11;
        end else if (snd_req) begin
          w_owner_nxt = OWN_VID;
          w_snd_nxt   = 1'b1;
          w_addr_nxt  = snd_addr;
          w_ds_nxt    = 2'b11;
        end else if (r_pending) begin
          w_owner_nxt   = OWN_REF;
          w_pending_nxt = 1'b0;
`ifdef MEM_ARB_CPU_STEAL_EN
        end else if (cpu_req) begin
          w_owner_nxt  = OWN_CPU;
          w_we_nxt     = cpu_we;
          w_ack_ok_nxt = 1'b1;
          w_addr_nxt   = cpu_addr;
          w_ds_nxt     = cpu_ds;
`endif
        end
      end else begin
        if (cpu_req) begin
          w_owner_nxt  = OWN_CPU;
          w_we_nxt     = cpu_we;
          w_ack_ok_nxt = 1'b1;
          w_addr_nxt   = cpu_addr;
          w_ds_nxt     = cpu_ds;
        end else if (r_pending) begin
          w_owner_nxt   = OWN_REF;
          w_pending_nxt = 1'b0;
        end
      end
      // A period expiring in the same wrap as a refresh grant re-arms pending.
      if (r_cnt == CNT_LAST) begin
        w_cnt_nxt     = '0;
        w_pending_nxt = 1'b1;
      end else begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
      end
    end

    // Outputs are registered against the phase being entered so they line up with bus_phase.
    w_cpu_nxt   = (w_owner_nxt == OWN_CPU);
    w_rd_span   = (w_phase_nxt >= 3'd1) && (w_phase_nxt <= 3'd5);
    w_wr_span   = (w_phase_nxt >= 3'd2) && (w_phase_nxt <= 3'd5);
    w_oe        = w_rd_span && ((w_cpu_nxt && !w_we_nxt) || (w_owner_nxt == OWN_VID));
    w_wen       = w_wr_span && w_cpu_nxt && w_we_nxt;
    w_refresh   = (w_owner_nxt == OWN_REF) && (w_phase_nxt == 3'd1);
    w_ack       = w_cpu_nxt && w_ack_ok_nxt && (w_phase_nxt >= 3'd4);
    w_vid_valid = clk8_en_p && (r_phase == 3'd5) && (r_owner == OWN_VID) && !r_snd;
    w_snd_valid = clk8_en_p && (r_phase == 3'd5) && (r_owner == OWN_VID) && r_snd;
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_phase     <= 3'd0;
      r_slot_vid  <= 1'b0;
      r_owner     <= OWN_IDLE;
      r_snd       <= 1'b0;
      r_we        <= 1'b0;
      r_ack_ok    <= 1'b0;
      r_cnt       <= '0;
      r_pending   <= 1'b0;
      r_addr      <= '0;
      r_ds        <= 2'b00;
      r_oe        <= 1'b0;
      r_wen       <= 1'b0;
      r_refresh   <= 1'b0;
      r_ack       <= 1'b0;
      r_vid_valid <= 1'b0;
      r_snd_valid <= 1'b0;
    end else begin
      r_phase     <= w_phase_nxt;
      r_slot_vid  <= w_slot_vid_nxt;
      r_owner     <= w_owner_nxt;
      r_snd       <= w_snd_nxt;
      r_we        <= w_we_nxt;
      r_ack_ok    <= w_ack_ok_nxt;
      r_cnt       <= w_cnt_nxt;
      r_pending   <= w_pending_nxt;
      r_addr      <= w_addr_nxt;
      r_ds        <= w_ds_nxt;
      r_oe        <= w_oe;
      r_wen       <= w_wen;
      r_refresh   <= w_refresh;
      r_ack       <= w_ack;
      r_vid_valid <= w_vid_valid;
      r_snd_valid <= w_snd_valid;
    end
  end

  assign bus_phase   = r_phase;
  assign ram_addr    = r_addr;
  assign ram_ds      = r_ds;
  assign ram_oe      = r_oe;
  assign ram_we      = r_wen;
  assign ram_refresh = r_refresh;
  assign cpu_ack     = r_ack;
  assign vid_valid   = r_vid_valid;
  assign snd_valid   = r_snd_valid;
  assign slot_owner  = r_owner;

endmodule

// File: tb/tb_mac_ram_scheduler.sv
// Directed bench for mac_ram_scheduler (REFRESH_PERIOD=4): reset, CPU read/write, video/sound, refresh, steal, async reset.
module tb_mac_ram_scheduler;

  localparam int AW = 21;
`ifdef MEM_ARB_CPU_STEAL_EN
  localparam logic STEAL = 1'b1;
`else
  localparam logic STEAL = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          n_reset;
  logic          clk8_en_p;
  logic          cpu_req, cpu_we, vid_req, snd_req;
  logic [1:0]    cpu_ds;
  logic [AW-1:0] cpu_addr, vid_addr, snd_addr;
  logic [2:0]    bus_phase;
  logic [AW-1:0] ram_addr;
  logic [1:0]    ram_ds, slot_owner;
  logic          ram_oe, ram_we, ram_refresh, cpu_ack, vid_valid, snd_valid;

  int n_chk = 0;
  int n_pass = 0;
  int e_phase = 0;
  int e_slot = 0;
  logic seen_cmd;

  mac_ram_scheduler #(.ADDR_W(AW), .REFRESH_PERIOD(4)) dut (
    .clk(clk), .n_reset(n_reset), .clk8_en_p(clk8_en_p),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_ds(cpu_ds), .cpu_addr(cpu_addr),
    .vid_req(vid_req), .vid_addr(vid_addr), .snd_req(snd_req), .snd_addr(snd_addr),
    .bus_phase(bus_phase), .ram_addr(ram_addr), .ram_ds(ram_ds), .ram_oe(ram_oe),
    .ram_we(ram_we), .ram_refresh(ram_refresh), .cpu_ack(cpu_ack),
    .vid_valid(vid_valid), .snd_valid(snd_valid), .slot_owner(slot_owner)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // driver tasks
  task automatic clk1();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    clk8_en_p = 1'b1;
    @(posedge clk);
    #1;
    clk8_en_p = 1'b0;
    e_phase = (e_phase + 1) % 8;
    if (e_phase == 0) e_slot++;
  endtask

  task automatic goto(input int slot, input int ph);
    int guard;
    guard = 0;
    while (!(e_slot == slot && e_phase == ph) && guard < 400) begin
      tick();
      guard++;
    end
    chk("goto_phase", {29'd0, bus_phase}, ph[31:0]);
    if (guard >= 400) chk("goto_budget", 32'(guard), 32'd0);
  endtask

  initial begin
    n_reset = 1'b0; clk8_en_p = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_ds = 2'b00; cpu_addr = '0;
    vid_req = 1'b0; vid_addr = '0; snd_req = 1'b0; snd_addr = '0;
    repeat (3) clk1();
    chk("rst_phase", {29'd0, bus_phase}, 32'd0);
    chk("rst_owner", {30'd0, slot_owner}, 32'd0);
    chk("rst_outs", {ram_oe, ram_we, ram_refresh, cpu_ack, vid_valid, snd_valid}, 32'd0);
    chk("rst_addr", 32'(ram_addr), 32'd0);
    n_reset = 1'b1;
    clk1();
    chk("hold_no_en", {29'd0, bus_phase}, 32'd0);

    // Idle run: 32 ticks, no commands; pending appears at wrap 4, refresh in slot 5
    seen_cmd = 1'b0;
    for (int i = 0; i < 32; i++) begin
      tick();
      chk("idle_phase", {29'd0, bus_phase}, 32'((i + 1) % 8));
      seen_cmd = seen_cmd | ram_oe | ram_we | cpu_ack | ram_refresh | (slot_owner != 2'd0);
    end
    chk("idle_no_cmd", {31'd0, seen_cmd}, 32'd0);
    goto(5, 0);
    chk("ref1_owner", {30'd0, slot_owner}, 32'd3);
    chk("ref1_p0", {31'd0, ram_refresh}, 32'd0);
    tick();
    chk("ref1_p1", {31'd0, ram_refresh}, 32'd1);
    tick();
    chk("ref1_p2", {31'd0, ram_refresh}, 32'd0);

    // CPU read in slot 6
    goto(5, 7);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_ds = 2'b11; cpu_addr = 21'h12345;
    tick();
    chk("rd_owner", {30'd0, slot_owner}, 32'd1);
    chk("rd_addr", 32'(ram_addr), 32'h12345);
    chk("rd_ds", {30'd0, ram_ds}, 32'd3);
    chk("rd_oe_p0", {31'd0, ram_oe}, 32'd0);
    for (int p = 1; p < 8; p++) begin
      tick();
      chk("rd_oe", {31'd0, ram_oe}, (p <= 5) ? 32'd1 : 32'd0);
      chk("rd_ack", {31'd0, cpu_ack}, (p >= 4) ? 32'd1 : 32'd0);
      chk("rd_we", {31'd0, ram_we}, 32'd0);
    end
    cpu_req = 1'b0;
    clk1();
    chk("rd_ack_drop", {31'd0, cpu_ack}, 32'd0);
    chk("rd_drop_phase", {29'd0, bus_phase}, 32'd7);

    // VIDEO slot 7 idle, CPU write ds=01 in slot 8, req dropped at phase 3
    tick();
    chk("v7_owner", {30'd0, slot_owner}, 32'd0);
    goto(7, 7);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_ds = 2'b01; cpu_addr = 21'h0ABCD;
    tick();
    chk("wr_owner", {30'd0, slot_owner}, 32'd1);
    chk("wr_addr", 32'(ram_addr), 32'h0ABCD);
    chk("wr_ds", {30'd0, ram_ds}, 32'd1);
    for (int p = 1; p < 8; p++) begin
      tick();
      if (p == 3) cpu_req = 1'b0;
      chk("wr_we", {31'd0, ram_we}, (p >= 2 && p <= 5) ? 32'd1 : 32'd0);
      chk("wr_oe", {31'd0, ram_oe}, 32'd0);
      chk("wr_ack", {31'd0, cpu_ack}, 32'd0);
    end

    // Video and sound both requesting: video in slot 9, refresh in 10, sound in 11
    vid_req = 1'b1; snd_req = 1'b1; vid_addr = 21'h1F000; snd_addr = 21'h1FF00;
    tick();
    chk("vid_owner", {30'd0, slot_owner}, 32'd2);
    chk("vid_addr", 32'(ram_addr), 32'h1F000);
    chk("vid_ds", {30'd0, ram_ds}, 32'd3);
    tick();
    chk("vid_oe_p1", {31'd0, ram_oe}, 32'd1);
    goto(9, 5);
    chk("vid_valid_p5", {31'd0, vid_valid}, 32'd0);
    tick();
    chk("vid_valid_p6", {31'd0, vid_valid}, 32'd1);
    chk("snd_valid_v", {31'd0, snd_valid}, 32'd0);
    clk1();
    chk("vid_valid_1clk", {31'd0, vid_valid}, 32'd0);
    goto(9, 7);
    vid_req = 1'b0;
    tick();
    chk("s10_ref_owner", {30'd0, slot_owner}, 32'd3);
    goto(11, 0);
    chk("snd_owner", {30'd0, slot_owner}, 32'd2);
    chk("snd_addr", 32'(ram_addr), 32'h1FF00);
    goto(11, 5);
    tick();
    chk("snd_valid_p6", {31'd0, snd_valid}, 32'd1);
    chk("vid_valid_s", {31'd0, vid_valid}, 32'd0);
    clk1();
    chk("snd_valid_1clk", {31'd0, snd_valid}, 32'd0);

    // Saturation: CPU and video hog slots 12..18, refresh lands in 19 only once
    goto(11, 7);
    snd_req = 1'b0; vid_req = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_ds = 2'b11; cpu_addr = 21'h00100;
    for (int s = 12; s <= 18; s++) begin
      goto(s, 0);
      chk("sat_owner", {30'd0, slot_owner}, (s % 2 == 0) ? 32'd1 : 32'd2);
    end
    goto(18, 7);
    cpu_req = 1'b0; vid_req = 1'b0;
    tick();
    chk("sat_ref_owner", {30'd0, slot_owner}, 32'd3);
    chk("sat_ref_addr", {9'd0, ram_ds, 21'(ram_addr)}, 32'd0);
    tick();
    chk("sat_ref_p1", {31'd0, ram_refresh}, 32'd1);
    tick();
    chk("sat_ref_p2", {31'd0, ram_refresh}, 32'd0);
    goto(20, 0);
    chk("sat_once", {30'd0, slot_owner}, 32'd0);
    goto(21, 0);
    chk("ref_next_period", {30'd0, slot_owner}, 32'd3);

    // CPU only: slot 22 CPU; slot 23 (video) served only when stealing
    goto(21, 7);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 21'h00200;
    goto(22, 0);
    chk("cpu_only_s22", {30'd0, slot_owner}, 32'd1);
    goto(23, 0);
    chk("steal_owner", {30'd0, slot_owner}, {31'd0, STEAL});
    goto(23, 4);
    chk("steal_ack", {31'd0, cpu_ack}, {31'd0, STEAL});

    // Async reset in the middle of a write
    goto(23, 7);
    cpu_we = 1'b1; cpu_addr = 21'h00777;
    tick();
    chk("rw_addr", 32'(ram_addr), 32'h00777);
    goto(24, 3);
    chk("rw_we_p3", {31'd0, ram_we}, 32'd1);
    #2 n_reset = 1'b0;
    #1;
    chk("arst_we", {31'd0, ram_we}, 32'd0);
    chk("arst_phase", {29'd0, bus_phase}, 32'd0);
    chk("arst_owner", {30'd0, slot_owner}, 32'd0);
    chk("arst_addr", 32'(ram_addr), 32'd0);
    chk("arst_outs", {ram_oe, ram_refresh, cpu_ack, vid_valid, snd_valid}, 32'd0);
    cpu_req = 1'b0;
    clk1();
    n_reset = 1'b1;
    clk1();

    // report
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mac_ram_scheduler.md
Name: mac_ram_scheduler

Overview:
Sequences the shared 16-bit RAM port of the Mac Plus core.
- Owns the 8-phase bus counter and alternates CPU and video time slots.
- Arbitrates each slot between CPU, video fetch, sound fetch and refresh.
- Drives the RAM address/strobe/command outputs and the CPU RAM acknowledge.
- Sits between the CPU/address decode and the SDRAM controller; replaces ad-hoc DTACK/phase gating.

Parameters:
ADDR_W, 21, RAM word address width
REFRESH_PERIOD, 64, slots between refresh requests (min 2)

Ports:
clk  in  1  system clock
n_reset  in  1  asynchronous active-low reset
clk8_en_p  in  1  8 MHz phase-advance enable
cpu_req  in  1  CPU RAM access pending (/AS low and RAM selected), level
cpu_we  in  1  1 = write
cpu_ds  in  2  {UDS,LDS} active-high byte strobes
cpu_addr  in  ADDR_W  CPU word address
vid_req  in  1  video word fetch request for next video slot, level
vid_addr  in  ADDR_W  video fetch address
snd_req  in  1  sound word fetch request, level
snd_addr  in  ADDR_W  sound fetch address
bus_phase  out  3  current phase 0..7
ram_addr  out  ADDR_W  address to RAM
ram_ds  out  2  byte strobes to RAM (11 for video/sound)
ram_oe  out  1  read enable
ram_we  out  1  write enable
ram_refresh  out  1  refresh command
cpu_ack  out  1  DTACK-equivalent, active high
vid_valid  out  1  video data capture strobe
snd_valid  out  1  sound data capture strobe
slot_owner  out  2  0 idle, 1 CPU, 2 video/sound, 3 refresh

Behaviour:
- Reset (async, n_reset low):
  - bus_phase=0, slot_type=CPU, refresh counter=0, pending=0.
  - All outputs 0; slot_owner=0.
- Phase counter: advances only on clk_p (clk8_en_p) ticks, wrapping 7->0. slot_type toggles CPU<->VIDEO on the 7->0 wrap.
- Grant: registered on the tick entering phase 0, from the request levels sampled that cycle. Held for the whole slot.
  - VIDEO slot priority: video > sound > refresh(pending) > idle.
  - CPU slot priority: cpu > refresh(pending) > idle.
  - A request asserted after phase 0 waits for the next eligible slot.
- Address mux: at phase 0 grant, ram_addr/ram_ds are loaded from the winner and held to phase 7. Idle/refresh slots drive address 0 and ds 00.
- Commands (all gated to the granted slot):
  - read: ram_oe=1 for phases 1..5.
  - write: ram_we=1 for phases 2..5.
  - refresh: ram_refresh=1 during phase 1 only.
- cpu_ack: =1 during phases 4..7 of a CPU-granted slot while cpu_req=1; 0 otherwise.
  - cpu_req dropping mid-slot deasserts cpu_ack next clk, but an issued write/read still runs to phase 5. No retry.
  - cpu_req still high at the next slot after ack is treated as a new access (CPU must drop /AS between cycles).
- Data strobes: vid_valid / snd_valid pulse for exactly one clk at the phase-6 tick of their slot.
- Refresh counter:
  - Increments per slot; at REFRESH_PERIOD-1 wraps to 0 and sets pending.
  - pending clears when a refresh is granted.
  - Period expiring while already pending: stays 1, no counting of missed refreshes.
- slot_owner reflects the current grant, updated at phase 0.
- Simultaneous vid_req and snd_req: video wins; sound retries next video slot.

Optional Feature:
MEM_ARB_CPU_STEAL_EN
- Defined: a VIDEO slot with no video, sound or pending-refresh request at phase 0 is granted to the CPU if cpu_req=1. Full CPU timing and cpu_ack apply, and slot_owner=1.
- Undefined: CPU accesses occur only in CPU slots; idle video slots stay idle.

Test Plan:
- Reset release, no requests, 32 clk_p ticks -> bus_phase cycles 0..7 four times; ram_oe/ram_we/cpu_ack never 1; refresh at the first slot where pending is set.
- cpu_req=1 read at addr 0x12345 before a CPU-slot phase 0 -> ram_addr=0x12345, ram_oe phases 1..5, cpu_ack phases 4..7; drop req at phase 7 -> ack 0.
- CPU write ds=01 -> ram_we phases 2..5 only, ram_ds=01; cpu_req dropped at phase 3 -> cpu_ack never 1, ram_we still through phase 5.
- vid_req and snd_req both held -> video granted in the first VIDEO slot, sound in the next; vid_valid and snd_valid each one clk at phase 6.
- REFRESH_PERIOD=4, continuous cpu_req and vid_req for 20 slots -> pending saturates; refresh granted once both requesters drop; ram_refresh single phase-1 pulse, slot_owner=3.
- With MEM_ARB_CPU_STEAL_EN, cpu_req only, video idle -> CPU served in consecutive slots (both types); without the macro, only every other slot.
- Assert n_reset low at phase 3 of a write -> ram_we drops immediately, bus_phase=0, all outputs 0.
